// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory req/ack port, decoder valid/ready port,
// execute-stage redirect and the stall counter observation port.
interface fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [15:0] pc_out;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_stalls;

  // The fetch unit drives the master side.
  modport master (
    output mem_req, mem_addr, instr_valid, instruction, pc_out, fetch_stalls,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory, decoder and execute stage together form the slave side.
  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, pc_out, fetch_stalls,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: two 16-bit reads per 32-bit instruction, PC and redirects.
// Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam logic [15:0] RST_PC = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO, HOLD} state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_pc, w_pc_nx;
  logic [15:0] r_addr, w_addr_nx;
  logic        r_drop, w_drop_nx;
  logic [31:0] r_instr;
  logic        w_ld_hi, w_ld_lo;
  logic        w_fetching;
  logic [15:0] w_tgt;

  assign w_tgt      = bus.redirect_pc & 16'hFFFE;
  assign w_fetching = (r_state == FETCH_HI) || (r_state == FETCH_LO);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_addr_nx  = r_addr;
    w_drop_nx  = r_drop;
    w_ld_hi    = 1'b0;
    w_ld_lo    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.redirect) w_pc_nx = w_tgt;
        w_state_nx = FETCH_HI;
      end
      FETCH_HI, FETCH_LO: begin
        if (bus.mem_ack) begin
          if (bus.redirect || r_drop) begin
            if (bus.redirect) w_pc_nx = w_tgt;
            w_drop_nx  = 1'b0;
            w_state_nx = FETCH_HI;
          end else if (r_state == FETCH_HI) begin
            w_ld_hi    = 1'b1;
            w_state_nx = FETCH_LO;
          end else begin
            w_ld_lo    = 1'b1;
            w_state_nx = HOLD;
          end
        end else if (bus.redirect) begin
          // The outstanding read keeps its address; its data is dropped on ack.
          w_pc_nx   = w_tgt;
          w_drop_nx = 1'b1;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          w_pc_nx    = w_tgt;
          w_state_nx = FETCH_HI;
        end else if (bus.instr_ready) begin
          w_pc_nx    = r_pc + 16'd2;
          w_state_nx = FETCH_HI;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // A new read starts whenever we enter a fetch state without one in flight.
    if ((w_state_nx == FETCH_HI || w_state_nx == FETCH_LO) && (!w_fetching || bus.mem_ack))
      w_addr_nx = (w_state_nx == FETCH_LO) ? w_pc_nx + 16'd1 : w_pc_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RST_PC;
      r_addr  <= RST_PC;
      r_drop  <= 1'b0;
      r_instr <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_addr  <= w_addr_nx;
      r_drop  <= w_drop_nx;
      if (w_ld_hi) r_instr[31:16] <= bus.mem_rdata;
      if (w_ld_lo) r_instr[15:0]  <= bus.mem_rdata;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stalls;

  // Only the fetch states have instr_valid low outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stalls <= 16'h0000;
    else if (w_fetching && (r_stalls != 16'hFFFF))
      r_stalls <= r_stalls + 16'd1;
  end

  assign bus.fetch_stalls = r_stalls;
`else
  assign bus.fetch_stalls = 16'h0000;
`endif

  assign bus.mem_req     = w_fetching;
  assign bus.mem_addr    = r_addr;
  assign bus.instr_valid = (r_state == HOLD);
  assign bus.instruction = r_instr;
  assign bus.pc_out      = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus directed
// sequences for wait states, redirect-while-waiting, PC wrap and async reset.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int mem_wait = 0;
  int wait_cnt = 0;

  function automatic logic [15:0] w(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [31:0] ins_at(input logic [15:0] pc);
    logic [15:0] p1;
    p1 = pc + 16'd1;
    return {w(pc), w(p1)};
  endfunction

  // Memory responder: ack after mem_wait idle cycles of each request.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wait_cnt < mem_wait) begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end else begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = w(bus.mem_addr);
        wait_cnt      = 0;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic req, input logic [15:0] addr,
                           input logic valid, input logic [15:0] pc, input logic [31:0] ins);
    check({tag, "_req"}, {31'd0, bus.mem_req}, {31'd0, req});
    check({tag, "_valid"}, {31'd0, bus.instr_valid}, {31'd0, valid});
    check({tag, "_pc"}, {16'd0, bus.pc_out}, {16'd0, pc});
    if (req)   check({tag, "_addr"}, {16'd0, bus.mem_addr}, {16'd0, addr});
    if (valid) check({tag, "_instr"}, bus.instruction, ins);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check({tag, "_instr"}, bus.instruction, 32'd0);
    check({tag, "_pc"}, {16'd0, bus.pc_out}, 32'd0);
    check({tag, "_stalls"}, {16'd0, bus.fetch_stalls}, 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int exp_stalls;
    logic [15:0] e_addr, e_pc;

    // ready, redir, rpc, req, addr, valid, pc, instr (rows are consecutive cycles)
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'h12345678};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'h12345678};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'h12345678};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'h12345678};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'h12345678};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'h12345678};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0002, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 16'h0002, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, ins_at(16'h0002)};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0004, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0004, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000, 1'b1, 16'h0004, ins_at(16'h0004)};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0100, 32'h0};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0, 16'h0100, 32'h0};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, ins_at(16'h0100)};

    rst_n           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    repeat (3) step();
    chk_reset("reset");
    rst_n = 1'b1;

    // Zero-wait fetches, HOLD back-pressure and a redirect out of HOLD.
    exp_stalls = 0;
    for (int i = 0; i < 18; i++) begin
      chk_state($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc, tbl[i].instr);
`ifdef FETCH_STALL_CNT_EN
      check($sformatf("row%0d_stalls", i), {16'd0, bus.fetch_stalls}, exp_stalls);
`else
      check($sformatf("row%0d_stalls", i), {16'd0, bus.fetch_stalls}, 32'd0);
`endif
      bus.instr_ready = tbl[i].ready;
      bus.redirect    = tbl[i].redir;
      bus.redirect_pc = tbl[i].rpc;
      if (tbl[i].req) exp_stalls++;
      step();
    end

    // Three wait cycles per word: address stable, valid 8 cycles after FETCH_HI entry.
    mem_wait        = 3;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk_state($sformatf("wait%0d", c), 1'b1, (c < 4) ? 16'h0102 : 16'h0103, 1'b0, 16'h0102, 32'h0);
      step();
    end
    chk_state("wait_done", 1'b0, 16'h0000, 1'b1, 16'h0102, ins_at(16'h0102));

    // Redirects while FETCH_LO is waiting: read completes, data dropped, refetch at target.
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    repeat (4) step();
    for (int c = 4; c < 16; c++) begin
      e_addr = (c < 8) ? 16'h0105 : ((c < 12) ? 16'h0040 : 16'h0041);
      e_pc   = (c == 4) ? 16'h0104 : ((c == 5) ? 16'h0030 : 16'h0040);
      chk_state($sformatf("drop%0d", c), 1'b1, e_addr, 1'b0, e_pc, 32'h0);
      bus.redirect    = (c == 4) || (c == 5);
      bus.redirect_pc = (c == 4) ? 16'h0031 : 16'h0041;
      step();
    end
    chk_state("drop_done", 1'b0, 16'h0000, 1'b1, 16'h0040, ins_at(16'h0040));

    // Redirect beats instr_ready in HOLD at 16'hFFFE, then plain consume wraps to 0.
    mem_wait        = 0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    step();
    bus.redirect = 1'b0;
    chk_state("c_hi", 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 32'h0);
    step();
    chk_state("c_lo", 1'b1, 16'hFFFF, 1'b0, 16'hFFFE, 32'h0);
    step();
    chk_state("c_hold", 1'b0, 16'h0000, 1'b1, 16'hFFFE, ins_at(16'hFFFE));
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    step();
    bus.redirect = 1'b0;
    chk_state("c_redir_wins", 1'b1, 16'h0200, 1'b0, 16'h0200, 32'h0);
    step();
    step();
    chk_state("c_hold2", 1'b0, 16'h0000, 1'b1, 16'h0200, ins_at(16'h0200));
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect = 1'b0;
    step();
    step();
    chk_state("c_hold3", 1'b0, 16'h0000, 1'b1, 16'hFFFE, ins_at(16'hFFFE));
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk_state("c_wrap_hi", 1'b1, 16'h0000, 1'b0, 16'h0000, 32'h0);
    step();
    chk_state("c_wrap_lo", 1'b1, 16'h0001, 1'b0, 16'h0000, 32'h0);

    // Asynchronous reset pulse in the middle of FETCH_LO.
    rst_n = 1'b0;
    #1;
    chk_reset("areset");
    step();
    chk_reset("areset_held");
    rst_n = 1'b1;
    chk_state("d_idle", 1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0);
    step();
    chk_state("d_hi", 1'b1, 16'h0000, 1'b0, 16'h0000, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
